// File: rtl/dds_pwm_pkg.sv
// Shared widths, configuration payload and period clamp for the DDS-driven PWM.
//   PERIOD_MIN : smallest effective PWM period in clocks
//   CNT_W      : period / counter / threshold width
//   SAMPLE_W   : DDS sample width
//   SCALE_W    : duty-scale gain width
package dds_pwm_pkg;

  localparam int unsigned PERIOD_MIN = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned SCALE_W    = 8;

  // Period and duty-scale travel together through holding and shadow registers.
  typedef struct packed {
    logic [CNT_W-1:0]   period;
    logic [SCALE_W-1:0] scale;
  } cfg_t;

  // Requested periods below the minimum (including zero) run at the minimum.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : p;
  endfunction

endpackage

// File: rtl/dds_pwm_scale.sv
// Sample capture and two-stage duty multiply pipeline.
//   clk, rst_n : clock, async active-low reset
//   clr        : forces thr_next to zero (PWM idle)
//   cap_en     : capture data_in into the sample register
//   mul1_en    : scaled   <= (sample * scale) >> SCALE_W
//   mul2_en    : thr_next <= (scaled * period) >> SAMPLE_W
//   data_in    : DDS sample
//   scale      : duty-scale shadow
//   period     : effective PWM period
//   thr_next   : high-time for the next PWM cycle
module dds_pwm_scale
  import dds_pwm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cap_en,
  input  logic                mul1_en,
  input  logic                mul2_en,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic [SCALE_W-1:0]  scale,
  input  logic [CNT_W-1:0]    period,
  output logic [CNT_W-1:0]    thr_next
);

  localparam int unsigned P1_W = SAMPLE_W + SCALE_W;
  localparam int unsigned P2_W = SAMPLE_W + CNT_W;

  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] scaled_q;
  logic [P1_W-1:0]     prod1;
  logic [P2_W-1:0]     prod2;

  // Full-width products; the shifts truncate, so scaled < 256 keeps thr_next < period.
  always_comb begin
    prod1 = P1_W'(sample_q) * P1_W'(scale);
    prod2 = P2_W'(scaled_q) * P2_W'(period);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      scaled_q <= '0;
      thr_next <= '0;
    end else begin
      if (cap_en) begin
        sample_q <= data_in;
      end
      if (mul1_en) begin
        scaled_q <= SAMPLE_W'(prod1 >> SCALE_W);
      end
      if (clr) begin
        thr_next <= '0;
      end else if (mul2_en) begin
        thr_next <= CNT_W'(prod2 >> SAMPLE_W);
      end
    end
  end

endmodule

// File: rtl/dds_pwm.sv
// PWM modulator driven by a DDS sample stream, with cycle-aligned config adoption.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   pwm_en             : run (1) / idle (0)
//   data_in            : DDS sample, valid every clock
//   period, duty_scale : requested configuration, captured on cfg_load
//   cfg_load           : one-clock request to adopt period/duty_scale
//   pwm_out            : registered PWM output
//   cycle_done         : pulse on the last clock of each PWM cycle
//   thr_active         : high-time of the current PWM cycle
module dds_pwm
  import dds_pwm_pkg::*;
#(
  parameter logic [CNT_W-1:0]   DEFAULT_PERIOD = 16'd1000,
  parameter logic [SCALE_W-1:0] DEFAULT_SCALE  = 8'd255
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pwm_en,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic [CNT_W-1:0]    period,
  input  logic [SCALE_W-1:0]  duty_scale,
  input  logic                cfg_load,
  output logic                pwm_out,
  output logic                cycle_done,
  output logic [CNT_W-1:0]    thr_active
);

  cfg_t             shadow_q;
  cfg_t             shadow_d;
  cfg_t             hold_q;
  cfg_t             cfg_req;
  logic             cfg_pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] p_eff;
  logic [CNT_W-1:0] p_next;
  logic [CNT_W-1:0] thr_d;
  logic [CNT_W-1:0] thr_next;
  logic             at_zero;
  logic             wrap;
  logic             pwm_d;
  logic             done_d;
  logic             mul1_en;
  logic             mul2_en;

  // Next-state decode; outputs are registered from next-state values so they
  // line up with the counter value they describe.
  always_comb begin
    cfg_req  = '{period: period, scale: duty_scale};
    p_eff    = eff_period(shadow_q.period);
    at_zero  = pwm_en && (cnt_q == '0);
    wrap     = pwm_en && (cnt_q >= p_eff - CNT_W'(1));
    mul1_en  = pwm_en && (cnt_q == CNT_W'(1));
    mul2_en  = pwm_en && (cnt_q == CNT_W'(2));

    // Shadows only move at cycle start; a request in that same clock wins.
    shadow_d = shadow_q;
    if (at_zero) begin
      if (cfg_load) begin
        shadow_d = cfg_req;
      end else if (cfg_pending_q) begin
        shadow_d = hold_q;
      end
    end
    p_next = eff_period(shadow_d.period);

    cnt_d = '0;
    if (pwm_en && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Threshold is loaded as the counter wraps so it is valid from cnt==0.
    thr_d = thr_active;
    if (!pwm_en) begin
      thr_d = '0;
    end else if (wrap) begin
      thr_d = thr_next;
    end

    pwm_d  = pwm_en && (cnt_d < thr_d);
    done_d = pwm_en && (cnt_d == p_next - CNT_W'(1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q         <= '0;
      shadow_q      <= '{period: DEFAULT_PERIOD, scale: DEFAULT_SCALE};
      hold_q        <= '{period: DEFAULT_PERIOD, scale: DEFAULT_SCALE};
      cfg_pending_q <= 1'b0;
      thr_active    <= '0;
      pwm_out       <= 1'b0;
      cycle_done    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      thr_active <= thr_d;
      pwm_out    <= pwm_d;
      cycle_done <= done_d;
      // Adoption at cycle start consumes any pending request.
      if (at_zero) begin
        cfg_pending_q <= 1'b0;
      end else if (cfg_load) begin
        cfg_pending_q <= 1'b1;
        hold_q        <= cfg_req;
      end
    end
  end

  dds_pwm_scale u_scale (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (!pwm_en),
    .cap_en   (at_zero),
    .mul1_en  (mul1_en),
    .mul2_en  (mul2_en),
    .data_in  (data_in),
    .scale    (shadow_q.scale),
    .period   (p_eff),
    .thr_next (thr_next)
  );

endmodule

// File: tb/tb_dds_pwm.sv
// Directed bench for dds_pwm: reset, duty math, period clamp, cfg timing,
// enable gating and mid-cycle reset.
module tb_dds_pwm;

  localparam int LIMIT = 3000;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        pwm_en;
  logic [7:0]  data_in;
  logic [15:0] period;
  logic [7:0]  duty_scale;
  logic        cfg_load;
  logic        pwm_out;
  logic        cycle_done;
  logic [15:0] thr_active;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dds_pwm #(
    .DEFAULT_PERIOD (16'd1000),
    .DEFAULT_SCALE  (8'd255)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pwm_en     (pwm_en),
    .data_in    (data_in),
    .period     (period),
    .duty_scale (duty_scale),
    .cfg_load   (cfg_load),
    .pwm_out    (pwm_out),
    .cycle_done (cycle_done),
    .thr_active (thr_active)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Observe one PWM cycle up to and including its cycle_done clock.
  // cfg_load is a one-clock pulse, so every loop drops it.
  task automatic measure_cycle(output int len, output int highs, output logic [15:0] thr);
    len   = 0;
    highs = 0;
    thr   = '0;
    do begin
      @(negedge sys_clk);
      cfg_load = 1'b0;
      if (len == 0) thr = thr_active;
      len++;
      if (pwm_out) highs++;
    end while (!cycle_done && len < LIMIT);
  endtask

  task automatic skip(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      cfg_load = 1'b0;
    end
  endtask

  task automatic test_reset;
    int bad;
    sys_rst_n  = 1'b0;
    pwm_en     = 1'b0;
    data_in    = '0;
    period     = '0;
    duty_scale = '0;
    cfg_load   = 1'b0;
    #25;
    total_cnt++;
    if (pwm_out !== 1'b0) $display("FAIL rst_pwm_out got %0b want 0", pwm_out);
    else pass_cnt++;
    total_cnt++;
    if (cycle_done !== 1'b0) $display("FAIL rst_cycle_done got %0b want 0", cycle_done);
    else pass_cnt++;
    total_cnt++;
    if (thr_active !== 16'd0) $display("FAIL rst_thr_active got %0d want 0", thr_active);
    else pass_cnt++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (pwm_out !== 1'b0 || cycle_done !== 1'b0 || thr_active !== 16'd0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL idle_after_reset got %0d bad clocks want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_half_duty;
    int len, highs;
    logic [15:0] thr;
    period     = 16'd256;
    duty_scale = 8'd255;
    data_in    = 8'd128;
    cfg_load   = 1'b1;
    pwm_en     = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (highs != 0) $display("FAIL half_first_highs got %0d want 0", highs);
    else pass_cnt++;
    total_cnt++;
    if (len != 255) $display("FAIL half_first_len got %0d want 255", len);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd127) $display("FAIL half_thr got %0d want 127", thr);
    else pass_cnt++;
    total_cnt++;
    if (highs != 127) $display("FAIL half_highs got %0d want 127", highs);
    else pass_cnt++;
    total_cnt++;
    if (len != 256) $display("FAIL half_len got %0d want 256", len);
    else pass_cnt++;
  endtask

  task automatic test_full_scale;
    int len, highs;
    logic [15:0] thr;
    period   = 16'd1000;
    data_in  = 8'd255;
    cfg_load = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 1000) $display("FAIL full_len got %0d want 1000", len);
    else pass_cnt++;
    total_cnt++;
    if (highs != 127) $display("FAIL full_carry_highs got %0d want 127", highs);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd992) $display("FAIL full_thr got %0d want 992", thr);
    else pass_cnt++;
    total_cnt++;
    if (highs != 992) $display("FAIL full_highs got %0d want 992", highs);
    else pass_cnt++;
    data_in = 8'd0;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (highs != 992) $display("FAIL full_latency_highs got %0d want 992", highs);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (highs != 0 || thr !== 16'd0) $display("FAIL zero_cycle got highs %0d thr %0d want 0 0", highs, thr);
    else pass_cnt++;
  endtask

  task automatic test_period_clamp;
    int len, highs;
    logic [15:0] thr;
    period   = 16'd2;
    cfg_load = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 4) $display("FAIL clamp2_len_a got %0d want 4", len);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 4) $display("FAIL clamp2_len_b got %0d want 4", len);
    else pass_cnt++;
    period   = 16'd8;
    cfg_load = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 8) $display("FAIL period8_len got %0d want 8", len);
    else pass_cnt++;
    period   = 16'd0;
    cfg_load = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 4) $display("FAIL clamp0_len got %0d want 4", len);
    else pass_cnt++;
  endtask

  task automatic test_cfg_timing;
    int len, highs, n;
    logic [15:0] thr;
    period   = 16'd1000;
    cfg_load = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 1000) $display("FAIL cfg_base_len got %0d want 1000", len);
    else pass_cnt++;
    skip(301);
    // counter now at 300: request a shorter period mid-cycle
    period   = 16'd500;
    cfg_load = 1'b1;
    n = 0;
    do begin
      @(negedge sys_clk);
      cfg_load = 1'b0;
      n++;
    end while (!cycle_done && n < LIMIT);
    total_cnt++;
    if (n != 699) $display("FAIL cfg_mid_finish got %0d want 699", n);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 500) $display("FAIL cfg_mid_next_len got %0d want 500", len);
    else pass_cnt++;
    @(negedge sys_clk);
    // counter now at 0: request applies to this cycle
    period   = 16'd300;
    cfg_load = 1'b1;
    n = 0;
    do begin
      @(negedge sys_clk);
      cfg_load = 1'b0;
      n++;
    end while (!cycle_done && n < LIMIT);
    total_cnt++;
    if (n != 299) $display("FAIL cfg_at_zero got %0d want 299", n);
    else pass_cnt++;
  endtask

  task automatic test_enable;
    int len, highs, bad;
    logic [15:0] thr;
    data_in = 8'd255;
    measure_cycle(len, highs, thr);
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd297 || highs != 297) $display("FAIL en_pre got thr %0d highs %0d want 297 297", thr, highs);
    else pass_cnt++;
    skip(100);
    pwm_en = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (pwm_out !== 1'b0 || cycle_done !== 1'b0 || thr_active !== 16'd0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL en_low_idle got %0d bad clocks want 0", bad);
    else pass_cnt++;
    pwm_en = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 299 || highs != 0) $display("FAIL en_first got len %0d highs %0d want 299 0", len, highs);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd297 || highs != 297 || len != 300) $display("FAIL en_second got thr %0d highs %0d len %0d want 297 297 300", thr, highs, len);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int len, highs;
    logic [15:0] thr;
    period     = 16'd600;
    duty_scale = 8'd200;
    cfg_load   = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 600) $display("FAIL rm_len got %0d want 600", len);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd466 || highs != 466) $display("FAIL rm_duty got thr %0d highs %0d want 466 466", thr, highs);
    else pass_cnt++;
    skip(401);
    total_cnt++;
    if (pwm_out !== 1'b1) $display("FAIL rm_pre_high got %0b want 1", pwm_out);
    else pass_cnt++;
    #5 sys_rst_n = 1'b0;
    #1;
    total_cnt++;
    if (pwm_out !== 1'b0 || thr_active !== 16'd0 || cycle_done !== 1'b0)
      $display("FAIL rm_async got pwm %0b thr %0d done %0b want 0 0 0", pwm_out, thr_active, cycle_done);
    else pass_cnt++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (len != 999 || highs != 0) $display("FAIL rm_first got len %0d highs %0d want 999 0", len, highs);
    else pass_cnt++;
    measure_cycle(len, highs, thr);
    total_cnt++;
    if (thr !== 16'd992 || highs != 992 || len != 1000) $display("FAIL rm_defaults got thr %0d highs %0d len %0d want 992 992 1000", thr, highs, len);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_full_scale();
    test_period_clamp();
    test_cfg_timing();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dds_pwm.md
DDS_PWM -- requirements
Module: dds_pwm

Interface
REQ-001 Parameter DEFAULT_PERIOD, 16'd1000, period shadow value after reset (clocks per PWM cycle).
REQ-002 Parameter DEFAULT_SCALE, 8'd255, duty-scale shadow value after reset.
REQ-003 sys_clk  input  1  system clock, 50 MHz; one clock; reset is asynchronous and active-low (sys_rst_n).
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 pwm_en  input  1  level; high runs the PWM, low idles it.
REQ-006 data_in  input  8  unsigned DDS waveform sample, from the DDS data_out, valid every clock.
REQ-007 period  input  16  requested PWM period in clocks.
REQ-008 duty_scale  input  8  amplitude gain, duty scaled by duty_scale/256.
REQ-009 cfg_load  input  1  single-cycle pulse requesting adoption of period/duty_scale.
REQ-010 pwm_out  output  1  registered PWM output.
REQ-011 cycle_done  output  1  single-cycle pulse on the last clock of each PWM cycle.
REQ-012 thr_active  output  16  high-time (clocks) of the current PWM cycle.

Function
REQ-013 Effective period P = max(period_shadow, 4); counter cnt runs 0..P-1, then wraps to 0.
REQ-014 At cnt==0, data_in is captured into sample_reg.
REQ-015 At cnt==1, scaled = (sample_reg * scale_shadow) >> 8, 8-bit result, truncating.
REQ-016 At cnt==2, thr_next = (scaled * P) >> 8, 16-bit result, truncating; always < P, so duty never reaches 100%.
REQ-017 At cnt==0, thr_active loads thr_next; sample-to-output latency is exactly one PWM cycle.
REQ-018 pwm_out is high on exactly the clocks of a PWM cycle where cnt < thr_active; driven from next-state values, no extra delay.
REQ-019 cycle_done is high exactly when pwm_en=1 and cnt==P-1.
REQ-020 A cfg_load pulse sets cfg_pending and latches period/duty_scale into a holding register; a later pulse before adoption overwrites the holding register.
REQ-021 At cnt==0 with cfg_pending set, the shadows take the held values and cfg_pending clears.
REQ-022 A cfg_load coinciding with cnt==0 takes effect in that same PWM cycle.
REQ-023 New P takes effect for the whole cycle starting at that cnt==0; no mid-cycle period change.
REQ-024 period < 4 clamps to 4; period==0 is legal and clamps to 4.
REQ-025 pwm_en low: cnt held at 0, pwm_out=0, cycle_done=0, thr_active=0, thr_next=0; shadows and cfg_pending retained.
REQ-026 The pwm_en rising edge starts at cnt==0. The first PWM cycle is all-low (thr_active=0); the sample from that cycle drives the second.

Reset
REQ-027 While sys_rst_n=0: cnt=0, sample_reg=0, scaled=0, thr_next=0, thr_active=0, pwm_out=0, cycle_done=0, cfg_pending=0, period shadow=DEFAULT_PERIOD, scale shadow=DEFAULT_SCALE.
REQ-028 Reset asserted mid-cycle returns every register to the REQ-027 values immediately, with no waiting for a clock edge.

Structure
REQ-029 Shared package dds_pwm_pkg holds PERIOD_MIN=4, CNT_W=16, SAMPLE_W=8, SCALE_W=8.
REQ-030 Sub-module dds_pwm_scale holds the two-stage multiply pipeline (REQ-015/016), with per-stage enables driven by cnt decode.
REQ-031 Top-level dds_pwm holds the counter, shadow/holding registers, enable logic and output compare.

Verification
REQ-032 Test: period=256, cfg_load, data_in=128, duty_scale=255. Required: from the third cycle onward, thr_active=127 and pwm_out high 127 of 256 clocks.
REQ-033 Test: period=1000, data_in=255, duty_scale=255. Required: thr_active=992; data_in=0 gives pwm_out low for the entire following cycle.
REQ-034 Test: period=2 with cfg_load. Required: cycle_done every 4 clocks; period=0 behaves identically.
REQ-035 Test: cfg_load period=500 at cnt==300 of a 1000-clock cycle. Required: the current cycle finishes at 1000; the next cycle_done comes 500 clocks later; cfg_load at cnt==0 applies immediately.
REQ-036 Test: pwm_en dropped mid-cycle, then raised. Required: pwm_out=0 while low; the first enabled cycle is all-low; cycle_done resumes after P clocks.
REQ-037 Test: sys_rst_n pulsed low at cnt==400. Required: pwm_out=0 and thr_active=0 at once; period returns to 1000 and scale to 255 after release.
